// File: rtl/multicycle_cpu.sv
// ---------------------------------------------------------------------------
// multicycle_cpu
//   Multi-cycle 8-register CPU sharing one req/ready memory port between
//   instruction fetch and LD/ST data transfers. Phases: FETCH -> EXEC
//   (-> MEM for LD/ST), HALT is terminal until reset.
//
// Parameters
//   DATA_W  datapath/register width (>= 16)
//   ADDR_W  PC / memory address width (>= 6, branch offset is 6 bits)
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous active-low reset
//   mem_req    memory transfer request
//   mem_we     write strobe (valid with mem_req)
//   mem_addr   transfer address
//   mem_wdata  store data
//   mem_rdata  read data, taken when mem_req & mem_ready
//   mem_ready  transfer completes this cycle
//   dbg_sel    register select for observation
//   dbg_reg    combinational R[dbg_sel]
//   PC, IR     program counter, instruction register
//   halted     core is in HALT
//
// Build option
//   MULTICYCLE_CPU_SHIFT_EN : adds SHR (0001101) and SHL (0001110);
//   without it those opcodes are NOPs.
// ---------------------------------------------------------------------------
module multicycle_cpu #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clock,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    input  logic [2:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_reg,
    output logic [ADDR_W-1:0] PC,
    output logic [15:0]       IR,
    output logic              halted
);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_MEM   = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    localparam logic [6:0] OP_MOVA = 7'b0000000;
    localparam logic [6:0] OP_INC  = 7'b0000001;
    localparam logic [6:0] OP_ADD  = 7'b0000010;
    localparam logic [6:0] OP_SUB  = 7'b0000101;
    localparam logic [6:0] OP_AND  = 7'b0001000;
    localparam logic [6:0] OP_OR   = 7'b0001001;
    localparam logic [6:0] OP_XOR  = 7'b0001010;
    localparam logic [6:0] OP_NOT  = 7'b0001011;
    localparam logic [6:0] OP_MOVB = 7'b0001100;
    localparam logic [6:0] OP_SHR  = 7'b0001101;
    localparam logic [6:0] OP_SHL  = 7'b0001110;
    localparam logic [6:0] OP_LD   = 7'b0010000;
    localparam logic [6:0] OP_ST   = 7'b0100000;
    localparam logic [6:0] OP_LDI  = 7'b1001100;
    localparam logic [6:0] OP_ADI  = 7'b1000010;
    localparam logic [6:0] OP_BRZ  = 7'b1100000;
    localparam logic [6:0] OP_BRN  = 7'b1100001;
    localparam logic [6:0] OP_JMP  = 7'b1110000;
    localparam logic [6:0] OP_HALT = 7'b1111111;

    logic [1:0]        state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [15:0]       ir_reg, ir_next;
    logic [DATA_W-1:0] regs [8];
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;

    logic [6:0]        opcode;
    logic [2:0]        dr, sa, sb;
    logic [DATA_W-1:0] sa_val, sb_val, imm;
    logic [ADDR_W-1:0] pc_inc, branch_target;

    assign opcode = ir_reg[15:9];
    assign dr     = ir_reg[8:6];
    assign sa     = ir_reg[5:3];
    assign sb     = ir_reg[2:0];
    assign sa_val = regs[sa];
    assign sb_val = regs[sb];
    assign imm    = {{(DATA_W-3){1'b0}}, sb};
    assign pc_inc = pc_reg + ADDR_W'(1);
    // 6-bit signed offset split across the DR and SB fields.
    assign branch_target = pc_reg + {{(ADDR_W-6){ir_reg[8]}}, ir_reg[8:6], ir_reg[2:0]};

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ir_next    = ir_reg;
        wr_en      = 1'b0;
        wr_data    = '0;
        case (state_reg)
            ST_FETCH: begin
                if (mem_ready) begin
                    ir_next    = mem_rdata[15:0];
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_next = ST_FETCH;
                pc_next    = pc_inc;
                case (opcode)
                    OP_MOVA: begin wr_en = 1'b1; wr_data = sa_val; end
                    OP_INC:  begin wr_en = 1'b1; wr_data = sa_val + DATA_W'(1); end
                    OP_ADD:  begin wr_en = 1'b1; wr_data = sa_val + sb_val; end
                    OP_SUB:  begin wr_en = 1'b1; wr_data = sa_val - sb_val; end
                    OP_AND:  begin wr_en = 1'b1; wr_data = sa_val & sb_val; end
                    OP_OR:   begin wr_en = 1'b1; wr_data = sa_val | sb_val; end
                    OP_XOR:  begin wr_en = 1'b1; wr_data = sa_val ^ sb_val; end
                    OP_NOT:  begin wr_en = 1'b1; wr_data = ~sa_val; end
                    OP_MOVB: begin wr_en = 1'b1; wr_data = sb_val; end
`ifdef MULTICYCLE_CPU_SHIFT_EN
                    OP_SHR:  begin wr_en = 1'b1; wr_data = sb_val >> 1; end
                    OP_SHL:  begin wr_en = 1'b1; wr_data = sb_val << 1; end
`endif
                    OP_LDI:  begin wr_en = 1'b1; wr_data = imm; end
                    OP_ADI:  begin wr_en = 1'b1; wr_data = sa_val + imm; end
                    OP_BRZ:  if (sa_val == '0) pc_next = branch_target;
                    OP_BRN:  if (sa_val[DATA_W-1]) pc_next = branch_target;
                    OP_JMP:  pc_next = sa_val[ADDR_W-1:0];
                    // PC advances only when the data transfer completes.
                    OP_LD, OP_ST: begin
                        pc_next    = pc_reg;
                        state_next = ST_MEM;
                    end
                    OP_HALT: begin
                        pc_next    = pc_reg;
                        state_next = ST_HALT;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                if (mem_ready) begin
                    if (opcode == OP_LD) begin
                        wr_en   = 1'b1;
                        wr_data = mem_rdata;
                    end
                    pc_next    = pc_inc;
                    state_next = ST_FETCH;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_FETCH;
            pc_reg    <= '0;
            ir_reg    <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ir_reg    <= ir_next;
        end
    end

    // One flop bank per register so the reset clears all eight at once.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_regs
            logic [DATA_W-1:0] r_reg;
            always_ff @(posedge clock or negedge reset) begin
                if (!reset)
                    r_reg <= '0;
                else if (wr_en && dr == 3'(gi))
                    r_reg <= wr_data;
            end
            assign regs[gi] = r_reg;
        end
    endgenerate

    // Request/strobe are gated by reset so an in-flight transfer is
    // abandoned the moment reset asserts, not at the next clock edge.
    assign mem_req   = reset && (state_reg == ST_FETCH || state_reg == ST_MEM);
    assign mem_we    = reset && (state_reg == ST_MEM) && (opcode == OP_ST);
    assign mem_addr  = (state_reg == ST_MEM)   ? sa_val[ADDR_W-1:0] :
                       (state_reg == ST_FETCH) ? pc_reg : '0;
    assign mem_wdata = mem_we ? sb_val : '0;

    assign dbg_reg = regs[dbg_sel];
    assign PC      = pc_reg;
    assign IR      = ir_reg;
    assign halted  = (state_reg == ST_HALT);

endmodule

// File: tb/tb_multicycle_cpu.sv
// ---------------------------------------------------------------------------
// tb_multicycle_cpu
//   Directed programs against multicycle_cpu with a unified memory model
//   that inserts a programmable number of wait-states per transfer.
// ---------------------------------------------------------------------------
module tb_multicycle_cpu;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        mem_req, mem_we, mem_ready;
    logic [9:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic [2:0]  dbg_sel = 3'd0;
    logic [15:0] dbg_reg;
    logic [9:0]  PC;
    logic [15:0] IR;
    logic        halted;

    int checks = 0;
    int failures = 0;

    logic [15:0] prog [1024];
    logic [15:0] mem  [1024];
    int          ws = 0;
    int          cnt = 0;
    int          wr_count = 0;
    logic [9:0]  wr_addr_seen = '0;
    logic [15:0] wr_data_seen = '0;

    multicycle_cpu #(.DATA_W(16), .ADDR_W(10)) dut (
        .clock     (clock),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .dbg_sel   (dbg_sel),
        .dbg_reg   (dbg_reg),
        .PC        (PC),
        .IR        (IR),
        .halted    (halted)
    );

    always #10 clock = ~clock;

    // Memory model: ready after ws stalled cycles; image reloaded from prog
    // on every clock edge while reset is held.
    assign mem_ready = mem_req && (cnt >= ws);
    assign mem_rdata = mem[mem_addr];

    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 1024; i++) mem[i] <= prog[i];
            cnt      <= 0;
            wr_count <= 0;
        end else if (mem_req && mem_ready) begin
            if (mem_we) begin
                mem[mem_addr] <= mem_wdata;
                wr_count      <= wr_count + 1;
                wr_addr_seen  <= mem_addr;
                wr_data_seen  <= mem_wdata;
            end
            cnt <= 0;
        end else if (mem_req) begin
            cnt <= cnt + 1;
        end else begin
            cnt <= 0;
        end
    end

    function automatic logic [15:0] enc(input logic [6:0] op, input logic [2:0] d,
                                        input logic [2:0] a, input logic [2:0] b);
        return {op, d, a, b};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=%0h", tag, got);
        end
    endtask

    task automatic check_reg(input string tag, input int idx, input logic [15:0] exp);
        dbg_sel = 3'(idx);
        #1;
        check_val(tag, {16'h0, dbg_reg}, {16'h0, exp});
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 1024; i++) prog[i] = 16'h0000;
    endtask

    // Hold reset over two edges (reloads memory), release on a falling edge.
    task automatic start();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    int req_seen;

    initial begin
        // ---------------- program A: LDI/LDI/SUB/ADD, zero wait ----------
        clear_prog();
        prog[0] = enc(7'b1001100, 3'd1, 3'd0, 3'd5);   // LDI R1,5
        prog[1] = enc(7'b1001100, 3'd2, 3'd0, 3'd3);   // LDI R2,3
        prog[2] = enc(7'b0000101, 3'd3, 3'd1, 3'd2);   // SUB R3,R1,R2
        prog[3] = enc(7'b0000010, 3'd4, 3'd3, 3'd1);   // ADD R4,R3,R1
        ws = 0;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_val("rst_req",    mem_req,   0);
        check_val("rst_we",     mem_we,    0);
        check_val("rst_addr",   mem_addr,  0);
        check_val("rst_wdata",  mem_wdata, 0);
        check_val("rst_pc",     PC,        0);
        check_val("rst_ir",     IR,        0);
        check_val("rst_halted", halted,    0);
        check_reg("rst_r7", 7, 16'h0);
        @(negedge clock);
        reset = 1'b1;
        run(7);
        check_val("alu_pc7", PC, 3);
        run(1);
        check_val("alu_pc8", PC, 4);
        check_reg("alu_r1", 1, 16'd5);
        check_reg("alu_r3", 3, 16'd2);
        check_reg("alu_r4", 4, 16'd7);

        // ---------------- reset mid-FETCH with ready held low ------------
        ws = 1000;
        run(2);
        check_val("stall_req",  mem_req,  1);
        check_val("stall_addr", mem_addr, 4);
        #3 reset = 1'b0;
        #1;
        check_val("mid_rst_req", mem_req, 0);
        check_val("mid_rst_we",  mem_we,  0);
        check_val("mid_rst_pc",  PC,      0);
        check_val("mid_rst_ir",  IR,      0);
        check_reg("mid_rst_r1", 1, 16'h0);
        check_reg("mid_rst_r4", 4, 16'h0);
        ws = 0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_val("restart_req",  mem_req,  1);
        check_val("restart_addr", mem_addr, 0);
        run(2);
        check_val("restart_pc", PC, 1);

        // ---------------- program B: ST/LD with 3 wait-states ------------
        clear_prog();
        prog[0] = enc(7'b1001100, 3'd3, 3'd0, 3'd7);   // LDI R3,7
        prog[1] = enc(7'b0010000, 3'd1, 3'd3, 3'd0);   // LD  R1,M[R3]
        prog[2] = enc(7'b0000001, 3'd3, 3'd3, 3'd0);   // INC R3,R3
        prog[3] = enc(7'b0010000, 3'd2, 3'd3, 3'd0);   // LD  R2,M[R3]
        prog[4] = enc(7'b0100000, 3'd0, 3'd1, 3'd2);   // ST  M[R1],R2
        prog[5] = enc(7'b0010000, 3'd5, 3'd1, 3'd0);   // LD  R5,M[R1]
        prog[6] = enc(7'b1111111, 3'd0, 3'd0, 3'd0);   // HALT
        prog[7] = 16'h0020;
        prog[8] = 16'hBEEF;
        ws = 3;
        start();
        run(28);
        check_val("ws_pc28", PC, 4);
        check_reg("ws_r1", 1, 16'h0020);
        check_reg("ws_r2", 2, 16'hBEEF);
        run(8);
        check_val("st_pc36",   PC,        4);
        check_val("st_req",    mem_req,   1);
        check_val("st_we",     mem_we,    1);
        check_val("st_addr",   mem_addr,  10'h020);
        check_val("st_wdata",  mem_wdata, 16'hBEEF);
        check_val("st_nowr",   wr_count,  0);
        run(1);
        check_val("st_pc37",   PC,           5);
        check_val("st_wrcnt",  wr_count,     1);
        check_val("st_wraddr", wr_addr_seen, 10'h020);
        check_val("st_wrdata", wr_data_seen, 16'hBEEF);
        run(9);
        check_val("ld_pc46", PC, 6);
        check_reg("ld_r5", 5, 16'hBEEF);

        // ---------------- program C: BRZ / BRN / JMP / NOT ----------------
        clear_prog();
        prog[0]  = enc(7'b1001100, 3'd1, 3'd0, 3'd5);    // LDI R1,5
        prog[1]  = enc(7'b0000010, 3'd1, 3'd1, 3'd1);    // ADD R1,R1,R1
        prog[2]  = enc(7'b1110000, 3'd0, 3'd1, 3'd0);    // JMP R1
        prog[6]  = enc(7'b1001100, 3'd0, 3'd0, 3'd1);    // LDI R0,1
        prog[7]  = enc(7'b1110000, 3'd0, 3'd1, 3'd0);    // JMP R1
        prog[10] = enc(7'b1100000, 3'b111, 3'd0, 3'b100); // BRZ R0,-4
        prog[11] = enc(7'b0001011, 3'd2, 3'd0, 3'd0);    // NOT R2,R0
        prog[12] = enc(7'b1100001, 3'd0, 3'd2, 3'd3);    // BRN R2,+3
        prog[15] = enc(7'b1111111, 3'd0, 3'd0, 3'd0);    // HALT
        ws = 0;
        start();
        run(6);
        check_val("jmp_pc10", PC, 10);
        run(2);
        check_val("brz_taken", PC, 6);
        run(6);
        check_val("brz_not", PC, 11);
        run(4);
        check_val("brn_taken", PC, 15);
        check_reg("not_r2", 2, 16'hFFFE);

        // ---------------- program D: BRN not taken at 1023 wraps ----------
        clear_prog();
        prog[0]    = enc(7'b1001100, 3'd2, 3'd0, 3'd4);  // LDI R2,4
        prog[1]    = enc(7'b0010000, 3'd1, 3'd2, 3'd0);  // LD  R1,M[R2]
        prog[2]    = enc(7'b1110000, 3'd0, 3'd1, 3'd0);  // JMP R1
        prog[4]    = 16'h03FF;
        prog[1023] = enc(7'b1100001, 3'd0, 3'd0, 3'd0);  // BRN R0
        start();
        run(7);
        check_val("wrap_pc1023", PC, 1023);
        run(2);
        check_val("wrap_pc0", PC, 0);

        // ---------------- program E: logic ops then HALT at 7 -------------
        clear_prog();
        prog[0] = enc(7'b1001100, 3'd1, 3'd0, 3'd6);   // LDI R1,6
        prog[1] = enc(7'b1001100, 3'd2, 3'd0, 3'd3);   // LDI R2,3
        prog[2] = enc(7'b0001000, 3'd3, 3'd1, 3'd2);   // AND R3
        prog[3] = enc(7'b0001001, 3'd4, 3'd1, 3'd2);   // OR  R4
        prog[4] = enc(7'b0001010, 3'd5, 3'd1, 3'd2);   // XOR R5
        prog[5] = enc(7'b0001100, 3'd6, 3'd0, 3'd2);   // MOVB R6
        prog[6] = enc(7'b1000010, 3'd7, 3'd1, 3'd7);   // ADI R7,R1,7
        prog[7] = enc(7'b1111111, 3'd0, 3'd0, 3'd0);   // HALT
        start();
        run(15);
        check_val("halt_pre",    halted, 0);
        check_val("halt_pre_pc", PC,     7);
        run(1);
        check_val("halt_set", halted, 1);
        check_reg("and_r3", 3, 16'd2);
        check_reg("or_r4",  4, 16'd7);
        check_reg("xor_r5", 5, 16'd5);
        check_reg("movb_r6", 6, 16'd3);
        check_reg("adi_r7", 7, 16'd13);
        req_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            if (mem_req) req_seen++;
        end
        check_val("halt_noreq", req_seen, 0);
        check_val("halt_pc",    PC,       7);
        check_val("halt_hold",  halted,   1);
        reset = 1'b0;
        #1;
        check_val("halt_rst", halted, 0);

        // ---------------- program F: SHR / SHL / MOVA ---------------------
        clear_prog();
        prog[0] = enc(7'b1001100, 3'd3, 3'd0, 3'd7);   // LDI R3,7
        prog[1] = enc(7'b0010000, 3'd2, 3'd3, 3'd0);   // LD  R2,M[R3]
        prog[2] = enc(7'b1001100, 3'd1, 3'd0, 3'd5);   // LDI R1,5
        prog[3] = enc(7'b0001101, 3'd1, 3'd0, 3'd2);   // SHR R1,R2
        prog[4] = enc(7'b0001110, 3'd4, 3'd0, 3'd2);   // SHL R4,R2
        prog[5] = enc(7'b0000000, 3'd6, 3'd2, 3'd0);   // MOVA R6,R2
        prog[6] = enc(7'b1111111, 3'd0, 3'd0, 3'd0);   // HALT
        prog[7] = 16'h8001;
        start();
        run(9);
        check_val("shr_pc", PC, 4);
`ifdef MULTICYCLE_CPU_SHIFT_EN
        check_reg("shr_r1", 1, 16'h4000);
`else
        check_reg("shr_r1", 1, 16'h0005);
`endif
        run(2);
        check_val("shl_pc", PC, 5);
`ifdef MULTICYCLE_CPU_SHIFT_EN
        check_reg("shl_r4", 4, 16'h0002);
`else
        check_reg("shl_r4", 4, 16'h0000);
`endif
        run(2);
        check_val("mova_pc", PC, 6);
        check_reg("mova_r6", 6, 16'h8001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_cpu.md
# multicycle_cpu

Multi-cycle, parametrised successor to the single-cycle computer. It uses the same 16-bit instruction format (opcode [15:9], DR [8:6], SA [5:3], SB [2:0]) and a reduced instruction set. Instructions and data share one memory port, and every transfer uses a req/ready handshake, so the core tolerates wait-states. It sits at the top of the computer design between a unified memory model and the debug and observation logic.

## Interface
- DATA_W, 16: datapath and register width; must be ≥16.
- ADDR_W, 10: PC and memory address width.
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_req  out  1  memory transfer request.
- mem_we  out  1  write strobe, valid while mem_req=1.
- mem_addr  out  ADDR_W  transfer address.
- mem_wdata  out  DATA_W  store data.
- mem_rdata  in  DATA_W  read data, sampled when mem_req & mem_ready.
- mem_ready  in  1  transfer completes this cycle.
- dbg_sel  in  3  register select for observation.
- dbg_reg  out  DATA_W  combinational read of R[dbg_sel].
- PC  out  ADDR_W  program counter.
- IR  out  16  instruction register.
- halted  out  1  core is in HALT.

## Operation
- The state machine has four states: FETCH, EXEC, MEM and HALT.
- **FETCH**
  - Drives mem_req=1, mem_we=0, mem_addr=PC.
  - On mem_ready: IR←mem_rdata[15:0], then go to EXEC.
- **EXEC**
  - For every instruction except LD, ST and HALT: execute, set PC←next, go to FETCH.
- **LD/ST**
  - Go to MEM.
  - MEM drives mem_req=1 and mem_addr=R[SA][ADDR_W-1:0].
  - ST also drives mem_we=1 and mem_wdata=R[SB].
  - On mem_ready: LD writes R[DR]←mem_rdata, PC←PC+1, go to FETCH.
- **HALT (1111111)**
  - Go to HALT; PC is not incremented.
  - Leave only via reset.
- **Opcodes**
  - 0000000 MOVA: R[DR]←R[SA]
  - 0000001 INC: R[DR]←R[SA]+1
  - 0000010 ADD: R[DR]←R[SA]+R[SB]
  - 0000101 SUB: R[DR]←R[SA]−R[SB]
  - 0001000 AND, 0001001 OR, 0001010 XOR
  - 0001011 NOT: R[DR]←~R[SA]
  - 0001100 MOVB: R[DR]←R[SB]
  - 0010000 LD, 0100000 ST
  - 1001100 LDI: R[DR]←zero-extended SB field
  - 1000010 ADI: R[DR]←R[SA] + zero-extended SB field
  - 1100000 BRZ: branch if R[SA]==0
  - 1100001 BRN: branch if R[SA][DATA_W-1]
  - 1110000 JMP: PC←R[SA][ADDR_W-1:0]
  - 1111111 HALT
- **Branches**
  - AD = sign-extended {IR[8:6], IR[2:0]}.
  - Taken: PC←PC+AD, where PC is the branch's own address.
  - Not taken: PC←PC+1.
- Unlisted opcodes execute as NOP: PC←PC+1, no writes.
- **Arithmetic**
  - All arithmetic is modulo 2^DATA_W; no status flags are kept.
  - PC arithmetic is modulo 2^ADDR_W (wraps).
- R0 is an ordinary writable register.

## Timing
- Reset (asynchronous, while reset=0):
  - State=FETCH; PC=0; IR=0; R0–R7=0; halted=0.
  - mem_req, mem_we, mem_addr and mem_wdata are all 0.
- mem_req and mem_we are decoded from state and IR, so they fall immediately when reset asserts mid-transfer. The transfer is abandoned, and the memory must not complete a write after req falls.
- mem_ready is ignored while mem_req=0.
- With zero wait-states:
  - ALU, branch, JMP and NOP take 2 cycles.
  - LD and ST take 3 cycles.
- Each wait-state adds exactly one cycle to the FETCH or MEM phase it occurs in.
- Address and data outputs stay stable while mem_req=1 and mem_ready=0.
- Register writes, IR and PC update on the rising edge that ends the phase.
- dbg_reg reflects a write on the cycle after that edge.
- halted=1 from the cycle after HALT's EXEC edge.

## Configuration
- MULTICYCLE_CPU_SHIFT_EN defined adds two opcodes:
  - 0001101 SHR: R[DR]←R[SB]>>1, zero fill.
  - 0001110 SHL: R[DR]←R[SB]<<1.
- Without it, both opcodes execute as NOP.

## Test plan
- Reset mid-FETCH with mem_ready=0 → mem_req drops in the same cycle; after release, PC=0, IR=0, all registers 0 and fetch restarts at address 0.
- Run LDI R1,5; LDI R2,3; SUB R3,R1,R2; ADD R4,R3,R1 with zero wait-states → R3=2, R4=7, PC=4 after 8 cycles.
- Set R1=0x0020 and R2=0xBEEF, run ST M[R1]←R2 then LD R5←M[R1], with mem_ready delayed 3 cycles on each transfer → write seen at address 0x020 with data 0xBEEF; R5=0xBEEF; each of these instructions takes 3+3+3 cycles (each of its FETCH and MEM phases takes 1+3 cycles).
- BRZ with R0=0 at PC=10 and AD=−4 → PC=6; with R0=1 → PC=11; BRN at PC=1023 not taken with ADDR_W=10 → PC wraps to 0.
- HALT at PC=7 → halted=1, PC stays 7, mem_req stays 0 for 20 cycles; reset clears halted.
- SHR R1←R2 with R2=0x8001 → R1=0x4000 when MULTICYCLE_CPU_SHIFT_EN is defined; R1 unchanged and PC advances by 1 when it is not.
